falling_block: RTL and testbench

//  Upstream feeder of the stack stage: spawns one block at a pseudo-random x with a

---
 rtl/sky_stacker_pkg.sv | 27 ++
 rtl/falling_block_lfsr16.sv | 15 +
 rtl/falling_block.sv | 172 +++++++++++++++++
 tb/tb_falling_block.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sky_stacker_pkg.sv
// Shared definitions for the sky-stacker game pipeline: screen geometry,
// block colour codes and the falling-block FSM state encoding.
package sky_stacker_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        COL_EMPTY = 2'b00,
        COL_A     = 2'b01,
        COL_B     = 2'b10,
        COL_C     = 2'b11
    } color_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SPAWN = 2'b01,
        ST_FALL  = 2'b10,
        ST_WAIT  = 2'b11
    } fall_state_t;

    // A spawned block must never carry the empty code.
    function automatic logic [1:0] nonzero_color(input logic [1:0] c);
        return (c == COL_EMPTY) ? COL_A : c;
    endfunction

endpackage

// File: rtl/falling_block_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the spawn randomiser.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk) begin
        if (rst) lfsr <= SEED;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

endmodule

// File: rtl/falling_block.sv
// Falling-block feeder: spawns a random block, drops it on divider ticks and
// reports caught/missed. Optional macro FALL_SPEEDUP_EN adds a catch-driven speed level.
//
// state | meaning
// IDLE  | not dropping; waits for start
// SPAWN | block just loaded (spawned=1), becomes active next cycle
// FALL  | block descends one step per tick until caught or missed
// WAIT  | gap of SPAWN_GAP ticks before the next spawn
module falling_block
    import sky_stacker_pkg::*;
#(
    parameter int unsigned DIV_BITS  = 18,
    parameter int unsigned FALL_STEP = 1,
    parameter int unsigned START_Y   = 0,
    parameter int unsigned MISS_Y    = 440,
    parameter int unsigned X_OFS     = 50,
    parameter int unsigned SPAWN_GAP = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       caught,
    output logic [9:0] fall_x,
    output logic [9:0] fall_y,
    output logic [1:0] fall_color,
    output logic       active,
    output logic       spawned,
    output logic       missed
);

    fall_state_t state, state_n;

    logic [15:0]         lfsr;
    logic [DIV_BITS-1:0] div_cnt;
    logic                tick;
    logic [7:0]          gap_cnt, gap_n;
    logic [9:0]          step;
    logic [10:0]         y_sum;
    logic                miss_hit;
    logic [9:0]          spawn_x;
    logic [1:0]          spawn_col;
    logic [9:0]          x_n, y_n;
    logic [1:0]          col_n;
    logic                active_n, spawned_n, missed_n;
    logic                lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign lfsr_unused = ^{lfsr[15:12], lfsr[9]};

`ifdef FALL_SPEEDUP_EN
    logic [2:0] level, level_n;
    assign step = 10'(FALL_STEP) + {7'd0, level};
`else
    assign step = 10'(FALL_STEP);
`endif

    assign tick      = (div_cnt == '0);
    assign y_sum     = {1'b0, fall_y} + {1'b0, step};
    assign miss_hit  = (y_sum >= 11'(MISS_Y));
    assign spawn_x   = {1'b0, lfsr[8:0]} + 10'(X_OFS);
    assign spawn_col = nonzero_color(lfsr[11:10]);

    always_ff @(posedge clk) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= div_cnt - DIV_BITS'(1);
    end

    always_comb begin
        state_n   = state;
        x_n       = fall_x;
        y_n       = fall_y;
        col_n     = fall_color;
        gap_n     = gap_cnt;
        spawned_n = 1'b0;
        missed_n  = 1'b0;
`ifdef FALL_SPEEDUP_EN
        level_n   = level;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_SPAWN;
                    x_n       = spawn_x;
                    y_n       = 10'(START_Y);
                    col_n     = spawn_col;
                    spawned_n = 1'b1;
`ifdef FALL_SPEEDUP_EN
                    level_n   = 3'd0;
`endif
                end
            end
            ST_SPAWN: state_n = ST_FALL;
            ST_FALL: begin
                // caught outranks a coincident miss tick
                if (caught) begin
                    state_n = ST_WAIT;
                    gap_n   = 8'(SPAWN_GAP);
`ifdef FALL_SPEEDUP_EN
                    level_n = (level == 3'd7) ? level : level + 3'd1;
`endif
                end else if (tick) begin
                    if (miss_hit) begin
                        state_n  = ST_WAIT;
                        gap_n    = 8'(SPAWN_GAP);
                        missed_n = 1'b1;
                    end else begin
                        y_n = y_sum[9:0];
                    end
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    if (gap_cnt <= 8'd1) begin
                        state_n   = ST_SPAWN;
                        x_n       = spawn_x;
                        y_n       = 10'(START_Y);
                        col_n     = spawn_col;
                        spawned_n = 1'b1;
                    end else begin
                        gap_n = gap_cnt - 8'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (stop) begin
            state_n   = ST_IDLE;
            x_n       = '0;
            y_n       = '0;
            col_n     = '0;
            spawned_n = 1'b0;
            missed_n  = 1'b0;
        end
        active_n = (state_n == ST_FALL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            fall_x     <= '0;
            fall_y     <= '0;
            fall_color <= '0;
            active     <= 1'b0;
            spawned    <= 1'b0;
            missed     <= 1'b0;
            gap_cnt    <= '0;
`ifdef FALL_SPEEDUP_EN
            level      <= '0;
`endif
        end else begin
            state      <= state_n;
            fall_x     <= x_n;
            fall_y     <= y_n;
            fall_color <= col_n;
            active     <= active_n;
            spawned    <= spawned_n;
            missed     <= missed_n;
            gap_cnt    <= gap_n;
`ifdef FALL_SPEEDUP_EN
            level      <= level_n;
`endif
        end
    end

endmodule

// File: tb/tb_falling_block.sv
// Directed bench for falling_block (DIV_BITS=4, SPAWN_GAP=2, MISS_Y=40):
// table of drop scenarios plus hand-written stop/idle sequences.
module tb_falling_block;

    localparam int DIV_BITS  = 4;
    localparam int SPAWN_GAP = 2;
    localparam int MISS_Y    = 40;
    localparam int X_OFS     = 50;
    localparam int FALL_STEP = 1;
    localparam int TICK      = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst, start, stop, caught;
    logic [9:0] fall_x, fall_y;
    logic [1:0] fall_color;
    logic active, spawned, missed;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int exp_spawn_edge = -1;
    int catches = 0;
    logic [15:0] m_lfsr, m_prev;

    typedef struct {
        string tag;
        int    catch_y;
        bit    on_tick;
        bit    exp_missed;
    } drop_vec_t;

    drop_vec_t tbl[4];

    falling_block #(
        .DIV_BITS  (DIV_BITS),
        .SPAWN_GAP (SPAWN_GAP),
        .MISS_Y    (MISS_Y)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .caught     (caught),
        .fall_x     (fall_x),
        .fall_y     (fall_y),
        .fall_color (fall_color),
        .active     (active),
        .spawned    (spawned),
        .missed     (missed)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Edge counter since reset release and a reference LFSR; m_prev is the
    // value the DUT saw before the most recent edge.
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (rst) begin
            cyc_n  <= 0;
            m_lfsr <= SEED;
        end else begin
            cyc_n  <= cyc_n + 1;
            m_lfsr <= lfsr_next(m_lfsr);
        end
    end

    function automatic bit is_tick(input int n);
        return ((n - 1) % TICK) == 0;
    endfunction

    function automatic int exp_step_now();
`ifdef FALL_SPEEDUP_EN
        return FALL_STEP + ((catches > 7) ? 7 : catches);
`else
        return FALL_STEP;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_drop(input string tag, input int catch_y, input bit on_tick, input bit exp_missed);
        int n, last_y, exp_y, y_bad, step, caught_edge, ex_x, ex_c, nt;
        bit sent, ended, fire;
        step = exp_step_now();
        caught = 1'b0;
        n = 0;
        while (spawned !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_spawn_seen"}, int'(spawned), 1);
        if (spawned !== 1'b1) return;
        if (exp_spawn_edge >= 0) chk({tag, "_spawn_edge"}, cyc_n, exp_spawn_edge);
        ex_x = int'({1'b0, m_prev[8:0]}) + X_OFS;
        ex_c = (m_prev[11:10] == 2'b00) ? 1 : int'(m_prev[11:10]);
        chk({tag, "_x"}, int'(fall_x), ex_x);
        chk({tag, "_x_range"}, int'(fall_x >= 10'd50 && fall_x <= 10'd561), 1);
        chk({tag, "_color"}, int'(fall_color), ex_c);
        chk({tag, "_y0"}, int'(fall_y), 0);
        chk({tag, "_active_at_load"}, int'(active), 0);
        @(negedge clk);
        chk({tag, "_active_after_load"}, int'(active), 1);
        chk({tag, "_spawned_width"}, int'(spawned), 0);
        @(negedge clk);
        last_y = 0; y_bad = 0; sent = 0; ended = 0; caught_edge = -1; n = 0;
        while (!ended && n < 3000) begin
            caught = 1'b0;
            if (active !== 1'b1) begin
                ended = 1;
            end else begin
                exp_y = is_tick(cyc_n) ? last_y + step : last_y;
                if (int'(fall_y) != exp_y) y_bad++;
                if (missed) y_bad++;
                last_y = int'(fall_y);
                if (!sent) begin
                    if (on_tick) fire = is_tick(cyc_n + 1) && (last_y + step >= MISS_Y);
                    else         fire = (catch_y >= 0) && (last_y >= catch_y);
                    if (fire) begin
                        caught = 1'b1;
                        sent = 1;
                        caught_edge = cyc_n + 1;
                    end
                end
                @(negedge clk);
                n++;
            end
        end
        chk({tag, "_ended"}, int'(ended), 1);
        if (!ended) return;
        chk({tag, "_y_track"}, y_bad, 0);
        chk({tag, "_missed"}, int'(missed), int'(exp_missed));
        chk({tag, "_y_hold"}, int'(fall_y), last_y);
        if (exp_missed) chk({tag, "_miss_y"}, int'(fall_y), ((MISS_Y - 1) / step) * step);
        else            chk({tag, "_catch_latency"}, cyc_n, caught_edge);
        if (!exp_missed) catches++;
        nt = cyc_n + TICK - ((cyc_n - 1) % TICK);
        exp_spawn_edge = nt + TICK * (SPAWN_GAP - 1);
        // stray caught during WAIT must not disturb anything
        caught = 1'b1;
        @(negedge clk);
        caught = 1'b0;
        chk({tag, "_missed_width"}, int'(missed), 0);
        chk({tag, "_wait_inactive"}, int'(active), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, n;
        tbl[0] = '{tag: "miss",      catch_y: -1, on_tick: 1'b0, exp_missed: 1'b1};
        tbl[1] = '{tag: "catch10",   catch_y: 10, on_tick: 1'b0, exp_missed: 1'b0};
        tbl[2] = '{tag: "catch_tie", catch_y: -1, on_tick: 1'b1, exp_missed: 1'b0};
        tbl[3] = '{tag: "catch5",    catch_y: 5,  on_tick: 1'b0, exp_missed: 1'b0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; caught = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", int'(fall_x), 0);
        chk("rst_y", int'(fall_y), 0);
        chk("rst_color", int'(fall_color), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_spawned", int'(spawned), 0);
        chk("rst_missed", int'(missed), 0);
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (active || spawned || missed || fall_x != 0 || fall_y != 0 || fall_color != 0) bad++;
        end
        chk("idle_hold", bad, 0);

        start = 1'b1;
        exp_spawn_edge = cyc_n + 1;
        catches = 0;
        for (int i = 0; i < 4; i++) run_drop(tbl[i].tag, tbl[i].catch_y, tbl[i].on_tick, tbl[i].exp_missed);

        start = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_wait_outs", int'(fall_x) + int'(fall_y) + int'(fall_color) + int'(active) + int'(spawned) + int'(missed), 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (active || spawned || missed) bad++;
        end
        chk("stop_wait_idle", bad, 0);

        start = 1'b1;
        exp_spawn_edge = cyc_n + 1;
        catches = 0;
        for (int i = 0; i < 9; i++) run_drop($sformatf("speed%0d", i), 12, 1'b0, 1'b0);

        n = 0;
        while (spawned !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("final_spawn_seen", int'(spawned), 1);
        repeat (20) @(negedge clk);
        chk("final_falling", int'(active), 1);
        start = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_fall_outs", int'(fall_x) + int'(fall_y) + int'(fall_color) + int'(active) + int'(spawned), 0);
        chk("stop_fall_missed", int'(missed), 0);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (active || spawned || missed) bad++;
        end
        chk("stop_fall_idle", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
